// File: rtl/systolic_feed_ctrl_if.sv
// Bundle between the host/DMA write path and the systolic feed sequencer.
//  master : host side, drives start and the activation/weight write ports
//  slave  : sequencer side, drives status, array clear, west feed and weights
//  start/ready/busy/done   run handshake and status
//  act_wr_* / wgt_wr_*     buffer write ports, row-major address i*N+j
//  arr_clr                 accumulator clear pulse to the array
//  west_out                slice r feeds array row r
//  weight_out              slice k is array weight k
interface systolic_feed_ctrl_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned N  = 3
);
   localparam int unsigned AW = (N * N > 1) ? $clog2(N * N) : 1;

   logic              start;
   logic              ready;
   logic              busy;
   logic              done;
   logic              act_wr_en;
   logic [AW-1:0]     act_wr_addr;
   logic [DW-1:0]     act_wr_data;
   logic              wgt_wr_en;
   logic [AW-1:0]     wgt_wr_addr;
   logic [DW-1:0]     wgt_wr_data;
   logic              arr_clr;
   logic [N*DW-1:0]   west_out;
   logic [N*N*DW-1:0] weight_out;

   modport master (
      output start, act_wr_en, act_wr_addr, act_wr_data, wgt_wr_en, wgt_wr_addr, wgt_wr_data,
      input  ready, busy, done, arr_clr, west_out, weight_out
   );

   modport slave (
      input  start, act_wr_en, act_wr_addr, act_wr_data, wgt_wr_en, wgt_wr_addr, wgt_wr_data,
      output ready, busy, done, arr_clr, west_out, weight_out
   );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for an NxN weight-stationary systolic array. Buffers an NxN activation matrix
// and NxN weights, then on start clears the array, streams activation columns into the
// west edge with row r delayed r cycles (zero-filled), waits DRAIN cycles and pulses done.
//  clk  : single rising-edge clock
//  rst  : synchronous reset, active-low
//  bus  : systolic_feed_ctrl_if slave (handshake, write ports, array-side outputs)
module systolic_feed_ctrl #(
   parameter int unsigned DW    = 32,
   parameter int unsigned N     = 3,
   parameter int unsigned DRAIN = 3
) (
   input logic                 clk,
   input logic                 rst,
   systolic_feed_ctrl_if.slave bus
);

   localparam int unsigned FCW = (2 * N - 1 > 1) ? $clog2(2 * N - 1) : 1;
   localparam int unsigned DCW = (DRAIN + 1 > 1) ? $clog2(DRAIN + 1) : 1;
   localparam logic [FCW-1:0] FeedLast  = FCW'(2 * N - 2);
   localparam logic [DCW-1:0] DrainLast = DCW'(DRAIN - 1);

   typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

   state_e            state_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;
   logic              clr_q;
   logic [N*DW-1:0]   west_q;
   logic [N*DW-1:0]   west_d;
   logic [FCW-1:0]    fcnt_q;
   logic [DCW-1:0]    dcnt_q;
   logic [DW-1:0]     act_q [N*N];
   logic [DW-1:0]     wgt_q [N*N];
   logic [N*N*DW-1:0] weight_flat;
   int                t_sel;

   // Buffers: written only while ready, out-of-range addresses dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(N * N); i++) begin
            act_q[i] <= '0;
            wgt_q[i] <= '0;
         end
      end else if (ready_q) begin
         if (bus.act_wr_en && (32'(bus.act_wr_addr) < N * N)) begin
            act_q[bus.act_wr_addr] <= bus.act_wr_data;
         end
         if (bus.wgt_wr_en && (32'(bus.wgt_wr_addr) < N * N)) begin
            wgt_q[bus.wgt_wr_addr] <= bus.wgt_wr_data;
         end
      end
   end

   // Feed word for the FEED cycle about to start: t=0 when leaving CLEAR, else current+1.
   // Row r carries A[t-r][r] inside the skew window, zero outside it.
   always_comb begin
      west_d = '0;
      t_sel  = (state_q == StClear) ? 0 : int'(fcnt_q) + 1;
      for (int r = 0; r < int'(N); r++) begin
         if ((t_sel - r >= 0) && (t_sel - r < int'(N))) begin
            west_d[r*DW +: DW] = act_q[(t_sel - r) * int'(N) + r];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         west_q  <= '0;
         fcnt_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         clr_q  <= 1'b0;
         west_q <= '0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q <= StClear;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  clr_q   <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
            StClear: begin
               state_q <= StFeed;
               fcnt_q  <= '0;
               west_q  <= west_d;
            end
            StFeed: begin
               if (fcnt_q == FeedLast) begin
                  if (DRAIN == 0) begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StDrain;
                     dcnt_q  <= '0;
                  end
               end else begin
                  fcnt_q <= fcnt_q + 1'b1;
                  west_q <= west_d;
               end
            end
            StDrain: begin
               if (dcnt_q == DrainLast) begin
                  state_q <= StDone;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      weight_flat = '0;
      for (int k = 0; k < int'(N * N); k++) begin
         weight_flat[k*DW +: DW] = wgt_q[k];
      end
   end

   assign bus.ready      = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.arr_clr    = clr_q;
   assign bus.west_out   = west_q;
   assign bus.weight_out = weight_flat;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned N  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   // Expected west sequence per row for A = 1..9 row-major.
   int row_seq [3][5] = '{'{1, 4, 7, 0, 0}, '{0, 2, 5, 8, 0}, '{0, 0, 3, 6, 9}};

   systolic_feed_ctrl_if #(.DW(DW), .N(N)) bus ();

   systolic_feed_ctrl #(.DW(DW), .N(N), .DRAIN(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [N*N*DW-1:0] got,
                        input logic [N*N*DW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [N*N*DW-1:0] west_exp(input int t, input bit zero);
      logic [N*N*DW-1:0] v;
      v = '0;
      if (!zero) begin
         for (int r = 0; r < 3; r++) v[r*DW +: DW] = DW'(row_seq[r][t]);
      end
      return v;
   endfunction

   function automatic logic [N*N*DW-1:0] wgt_exp(input bit zero);
      logic [N*N*DW-1:0] v;
      v = '0;
      if (!zero) begin
         for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(k + 1);
      end
      return v;
   endfunction

   // Writes A = W = 1..9 with simultaneous act and weight writes.
   task automatic load_all();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.act_wr_en   = 1'b1;
         bus.act_wr_addr = 4'(i);
         bus.act_wr_data = DW'(i + 1);
         bus.wgt_wr_en   = 1'b1;
         bus.wgt_wr_addr = 4'(i);
         bus.wgt_wr_data = DW'(i + 1);
      end
      @(negedge clk);
      bus.act_wr_en = 1'b0;
      bus.wgt_wr_en = 1'b0;
   endtask

   // Caller drives start=1 at the current negedge; the next posedge is edge k.
   task automatic expect_run(input bit poke, input bit chain, input bit zero);
      @(negedge clk);
      bus.start = 1'b0;
      check("clr_k1", 288'(bus.arr_clr), 288'(1));
      check("busy_k1", 288'({bus.busy, bus.ready}), 288'(2'b10));
      check("west_clear", 288'(bus.west_out), '0);
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         check($sformatf("west_t%0d", t), 288'(bus.west_out), west_exp(t, zero));
         if (t == 0) begin
            check("weights", bus.weight_out, wgt_exp(zero));
            check("clr_off", 288'(bus.arr_clr), '0);
         end
         if (poke && t == 1) begin
            bus.start       = 1'b1;
            bus.act_wr_en   = 1'b1;
            bus.act_wr_addr = 4'd0;
            bus.act_wr_data = DW'(99);
         end
         if (poke && t == 2) begin
            bus.start     = 1'b0;
            bus.act_wr_en = 1'b0;
         end
      end
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         check($sformatf("drain%0d", d), 288'({bus.done, bus.busy, bus.west_out}),
               288'({1'b0, 1'b1, 96'd0}));
      end
      @(negedge clk);
      check("done_k10", 288'({bus.done, bus.ready, bus.busy}), 288'(3'b110));
      if (chain) begin
         bus.start = 1'b1;
      end else begin
         @(negedge clk);
         check("after_done", 288'({bus.done, bus.ready, bus.busy}), 288'(3'b010));
      end
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.act_wr_en   = 1'b0;
      bus.act_wr_addr = '0;
      bus.act_wr_data = '0;
      bus.wgt_wr_en   = 1'b0;
      bus.wgt_wr_addr = '0;
      bus.wgt_wr_data = '0;

      // Reset held two cycles.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_status", 288'({bus.ready, bus.busy, bus.done, bus.arr_clr}), 288'(4'b1000));
      check("rst_west", 288'(bus.west_out), '0);
      check("rst_wgt", bus.weight_out, '0);
      rst = 1'b1;

      // Basic run.
      load_all();
      bus.start = 1'b1;
      expect_run(1'b0, 1'b0, 1'b0);

      // Start and write during FEED are ignored; single done pulse.
      bus.start = 1'b1;
      expect_run(1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("no_rerun", 288'({bus.done, bus.busy}), '0);
      end
      bus.start = 1'b1;
      expect_run(1'b0, 1'b0, 1'b0);

      // Back-to-back run from DONE.
      bus.start = 1'b1;
      expect_run(1'b0, 1'b1, 1'b0);
      expect_run(1'b0, 1'b0, 1'b0);

      // Reset during FEED cycle 3.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("feed3_west", 288'(bus.west_out), west_exp(3, 1'b0));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_status", 288'({bus.ready, bus.busy, bus.done}), 288'(3'b100));
      check("midrst_west", 288'(bus.west_out), '0);
      check("midrst_wgt", bus.weight_out, '0);
      repeat (8) begin
         @(negedge clk);
         check("midrst_nodone", 288'(bus.done), '0);
      end
      bus.start = 1'b1;
      expect_run(1'b0, 1'b0, 1'b1);

      // Out-of-range address ignored.
      load_all();
      @(negedge clk);
      bus.act_wr_en   = 1'b1;
      bus.act_wr_addr = 4'd9;
      bus.act_wr_data = DW'(5);
      bus.wgt_wr_en   = 1'b1;
      bus.wgt_wr_addr = 4'd9;
      bus.wgt_wr_data = DW'(5);
      @(negedge clk);
      bus.act_wr_en = 1'b0;
      bus.wgt_wr_en = 1'b0;
      check("oor_wgt", bus.weight_out, wgt_exp(1'b0));
      bus.start = 1'b1;
      expect_run(1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
